pump_sequencer: RTL and testbench
=================================

PUMP_SEQUENCER -- requirements
Module: pump_sequencer

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- RAMP_TICK_CYCLES, 50000: clk cycles between soft-start increments.
- RAMP_STEP, 16: duty increment per tick.
- DEAD_TIME_CYCLES, 500000: idle gap enforced between pump ownership changes.
- DUTY_A, 255: run duty for pump A.
- DUTY_B_MIN, 96: pump B MIN duty.
- DUTY_B_MAX, 255: pump B MAX duty.
REQ-002 Clocking: one clock; reset is asynchronous and active-high.
REQ-003 Ports (name, direction, width, meaning), one per line:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous active-high reset.
- pump_a_req  in  1  filter FSM requests pump A (fill).
- pump_b_mode  in  2  pump B request: 00 OFF, 01 MIN, 10 MAX, 11 reserved.
- duty_a  out  8  duty word to the pump A PWM generator.
- duty_b  out  8  duty word to the pump B PWM generator.
- owner  out  2  current owner: 00 NONE, 01 A, 10 B, 11 DEAD.
- ramping  out  1  active owner's duty is below its target.

Function
REQ-004 FSM states: NONE, RUN_A, RUN_B, DEAD.
REQ-005 NONE, B requested (mode 01/10) -> RUN_B; else A requested -> RUN_A; else stay. B has priority on simultaneous requests (drain beats fill).
REQ-006 RUN_A: pump_a_req low or B requested -> DEAD; duty_a forced to 0 in the same cycle the state registers DEAD.
REQ-007 RUN_B: pump_b_mode 00 -> DEAD with duty_b forced to 0; a pending A request does not pre-empt B.
REQ-008 DEAD: counter loads DEAD_TIME_CYCLES-1 on entry and decrements. At 0 -> NONE, and arbitration per REQ-005 applies on the next cycle. Both duties are 0 throughout DEAD.
REQ-009 Ramp on entry to RUN_x: duty starts at 0, then rises by RAMP_STEP every RAMP_TICK_CYCLES. The first increment occurs RAMP_TICK_CYCLES cycles after entry. Duty saturates at the target; 9-bit sum is clamped, never wraps past 255.
REQ-010 Targets: A = DUTY_A. B = DUTY_B_MIN for 01, DUTY_B_MAX for 10.
REQ-011 B target raised (01->10) in RUN_B: ramp continues upward from the current duty.
REQ-012 B target lowered (10->01) in RUN_B: duty_b drops to DUTY_B_MIN on the next cycle, with no ramp down.
REQ-013 pump_b_mode 11 is treated as holding the previous valid mode; from reset it is treated as OFF.
REQ-014 Non-owner duty is always 0; duty_a and duty_b are never both nonzero in any cycle.
REQ-015 ramping = 1 when state is RUN_x and duty_x < target; else 0.
REQ-016 All outputs are registered. Latency from request edge to state change is 1 cycle.

Reset
REQ-017 Reset asserted (any time, mid-ramp included): state NONE, duty_a = duty_b = 0, owner = 00, ramping = 0, tick and dead counters = 0, stored B mode = OFF.
REQ-018 After reset release, no DEAD gap is imposed; arbitration starts on the first clk edge.

Structure
REQ-019 Package pump_seq_pkg holds:
- owner_t enum (NONE, A, B, DEAD)
- b_mode_t enum (OFF, MIN, MAX, RSVD)
- DUTY_W = 8
REQ-020 One sub-module, duty_ramp: tick counter plus saturating step adder (inputs: enable, target, clear; output: duty). It is instantiated once per pump.

Verification
Bench parameters: RAMP_TICK_CYCLES=4, RAMP_STEP=16, DEAD_TIME_CYCLES=10, defaults otherwise.
REQ-021 Reset, then pump_a_req=1 -> owner=01 after 1 cycle. duty_a follows 16, 32, ... every 4 cycles and saturates at 255 after 64 cycles; ramping falls with the saturation.
REQ-022 In RUN_A at duty_a=255, set pump_a_req=0 and pump_b_mode=01 in the same cycle -> duty_a=0 and owner=11 next cycle. After 10 cycles owner=00, then 10, and duty_b ramps to 96 and holds.
REQ-023 In RUN_B at 96, mode 01->10 -> ramp continues 112...255. Then 10->01 -> duty_b=96 the next cycle.
REQ-024 pump_a_req=1 and pump_b_mode=10 asserted simultaneously from NONE -> owner=10 and duty_a stays 0. Mode 11 mid-RUN_B -> duty_b unchanged.
REQ-025 Assert reset mid-ramp (duty_b=48) -> all outputs 0 asynchronously, before the next clk edge.
REQ-026 Throughout all scenarios, assertion: duty_a != 0 and duty_b != 0 never hold in the same cycle.

Source files
------------

// File: rtl/pump_seq_pkg.sv
// rtl/pump_seq_pkg.sv - shared types and widths for the pump sequencer
package pump_seq_pkg;

    localparam int DUTY_W = 8;

    // Encoding doubles as the owner output word.
    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_A    = 2'b01,
        OWN_B    = 2'b10,
        OWN_DEAD = 2'b11
    } owner_t;

    typedef enum logic [1:0] {
        B_OFF  = 2'b00,
        B_MIN  = 2'b01,
        B_MAX  = 2'b10,
        B_RSVD = 2'b11
    } b_mode_t;

endpackage

// File: rtl/duty_ramp.sv
// rtl/duty_ramp.sv - soft-start tick counter with saturating duty step adder
module duty_ramp
    import pump_seq_pkg::*;
#(
    parameter int RAMP_TICK_CYCLES = 50000,
    parameter int RAMP_STEP        = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              clear,
    input  logic [DUTY_W-1:0] target,
    output logic [DUTY_W-1:0] duty,
    output logic              below
);

    localparam int TICK_W = (RAMP_TICK_CYCLES > 1) ? $clog2(RAMP_TICK_CYCLES) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(RAMP_TICK_CYCLES - 1);
    localparam logic [DUTY_W:0]   STEP      = (DUTY_W + 1)'(RAMP_STEP);

    logic [TICK_W-1:0] tick, tick_nxt;
    logic [DUTY_W-1:0] duty_nxt;
    logic [DUTY_W:0]   sum;

    always_comb begin
        tick_nxt = tick;
        duty_nxt = duty;
        sum      = {1'b0, duty} + STEP;
        if (clear) begin
            tick_nxt = '0;
            duty_nxt = '0;
        end else if (enable) begin
            // Tick phase keeps running through target changes so a raised target resumes on the same cadence.
            tick_nxt = (tick == TICK_LAST) ? '0 : tick + TICK_W'(1);
            if (duty > target) begin
                duty_nxt = target;
            end else if (tick == TICK_LAST) begin
                duty_nxt = (sum > {1'b0, target}) ? target : sum[DUTY_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick  <= '0;
            duty  <= '0;
            below <= 1'b0;
        end else begin
            tick  <= tick_nxt;
            duty  <= duty_nxt;
            below <= !clear && (duty_nxt < target);
        end
    end

endmodule

// File: rtl/pump_sequencer.sv
// rtl/pump_sequencer.sv - two-pump ownership arbiter with dead time and soft-start ramps
module pump_sequencer
    import pump_seq_pkg::*;
#(
    parameter int RAMP_TICK_CYCLES = 50000,
    parameter int RAMP_STEP        = 16,
    parameter int DEAD_TIME_CYCLES = 500000,
    parameter int DUTY_A           = 255,
    parameter int DUTY_B_MIN       = 96,
    parameter int DUTY_B_MAX       = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pump_a_req,
    input  logic [1:0]        pump_b_mode,
    output logic [DUTY_W-1:0] duty_a,
    output logic [DUTY_W-1:0] duty_b,
    output logic [1:0]        owner,
    output logic              ramping
);

    localparam int DEAD_W = (DEAD_TIME_CYCLES > 1) ? $clog2(DEAD_TIME_CYCLES) : 1;
    localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEAD_TIME_CYCLES - 1);

    owner_t            state, state_nxt;
    b_mode_t           b_mode_q, b_eff;
    logic [DEAD_W-1:0] dead_cnt;
    logic [DUTY_W-1:0] target_b;
    logic              b_req, below_a, below_b;

    always_comb begin
        // Reserved mode code means "keep whatever B was last asked to do".
        b_eff = b_mode_t'(pump_b_mode);
        if (b_eff == B_RSVD) begin
            b_eff = b_mode_q;
        end
        b_req = (b_eff == B_MIN) || (b_eff == B_MAX);

        case (b_eff)
            B_MIN:   target_b = DUTY_W'(DUTY_B_MIN);
            B_MAX:   target_b = DUTY_W'(DUTY_B_MAX);
            default: target_b = '0;
        endcase

        state_nxt = state;
        case (state)
            OWN_NONE: begin
                if (b_req) begin
                    state_nxt = OWN_B;
                end else if (pump_a_req) begin
                    state_nxt = OWN_A;
                end
            end
            OWN_A:    if (!pump_a_req || b_req) state_nxt = OWN_DEAD;
            OWN_B:    if (!b_req) state_nxt = OWN_DEAD;
            OWN_DEAD: if (dead_cnt == '0) state_nxt = OWN_NONE;
            default:  state_nxt = OWN_NONE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= OWN_NONE;
            b_mode_q <= B_OFF;
            dead_cnt <= '0;
        end else begin
            state    <= state_nxt;
            b_mode_q <= b_eff;
            if (state_nxt == OWN_DEAD && state != OWN_DEAD) begin
                dead_cnt <= DEAD_LOAD;
            end else if (dead_cnt != '0) begin
                dead_cnt <= dead_cnt - DEAD_W'(1);
            end
        end
    end

    // Clearing on the next state zeroes a duty in the same edge its pump loses ownership.
    duty_ramp #(
        .RAMP_TICK_CYCLES(RAMP_TICK_CYCLES),
        .RAMP_STEP       (RAMP_STEP)
    ) u_ramp_a (
        .clk   (clk),
        .reset (reset),
        .enable(state == OWN_A),
        .clear (state_nxt != OWN_A),
        .target(DUTY_W'(DUTY_A)),
        .duty  (duty_a),
        .below (below_a)
    );

    duty_ramp #(
        .RAMP_TICK_CYCLES(RAMP_TICK_CYCLES),
        .RAMP_STEP       (RAMP_STEP)
    ) u_ramp_b (
        .clk   (clk),
        .reset (reset),
        .enable(state == OWN_B),
        .clear (state_nxt != OWN_B),
        .target(target_b),
        .duty  (duty_b),
        .below (below_b)
    );

    assign owner   = state;
    assign ramping = below_a | below_b;

endmodule

// File: tb/tb_pump_sequencer.sv
// tb/tb_pump_sequencer.sv - randomized self-checking bench for pump_sequencer
module tb_pump_sequencer;

    localparam int TICK = 4;
    localparam int STEP = 16;
    localparam int DEAD = 10;
    localparam int DA   = 255;
    localparam int BMIN = 96;
    localparam int BMAX = 255;

    logic       clk = 1'b0;
    logic       reset;
    logic       pump_a_req;
    logic [1:0] pump_b_mode;
    logic [7:0] duty_a;
    logic [7:0] duty_b;
    logic [1:0] owner;
    logic       ramping;

    int checks = 0;
    int errors = 0;

    // Reference model: owner, cycles since entering it, duties, last valid B mode.
    int m_owner, m_n, m_da, m_db, m_mode, m_ramp;

    pump_sequencer #(
        .RAMP_TICK_CYCLES(TICK),
        .RAMP_STEP       (STEP),
        .DEAD_TIME_CYCLES(DEAD),
        .DUTY_A          (DA),
        .DUTY_B_MIN      (BMIN),
        .DUTY_B_MAX      (BMAX)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pump_a_req (pump_a_req),
        .pump_b_mode(pump_b_mode),
        .duty_a     (duty_a),
        .duty_b     (duty_b),
        .owner      (owner),
        .ramping    (ramping)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int b_target(input int mode);
        if (mode == 1) return BMIN;
        if (mode == 2) return BMAX;
        return 0;
    endfunction

    function automatic int min2(input int x, input int y);
        return (x > y) ? y : x;
    endfunction

    task automatic model_reset();
        m_owner = 0;
        m_n     = 0;
        m_da    = 0;
        m_db    = 0;
        m_mode  = 0;
        m_ramp  = 0;
    endtask

    task automatic model_edge(input int a, input int mode);
        int eff;
        int tgt;
        eff    = (mode == 3) ? m_mode : mode;
        m_mode = eff;
        tgt    = b_target(eff);
        case (m_owner)
            0: begin
                if (eff != 0) begin
                    m_owner = 2; m_n = 0; m_db = 0;
                end else if (a != 0) begin
                    m_owner = 1; m_n = 0; m_da = 0;
                end
            end
            1: begin
                if (a == 0 || eff != 0) begin
                    m_owner = 3; m_n = 0; m_da = 0;
                end else begin
                    m_n++;
                    if (m_n % TICK == 0) m_da = min2(m_da + STEP, DA);
                end
            end
            2: begin
                if (eff == 0) begin
                    m_owner = 3; m_n = 0; m_db = 0;
                end else begin
                    m_n++;
                    if (m_db > tgt) m_db = tgt;
                    else if (m_n % TICK == 0) m_db = min2(m_db + STEP, tgt);
                end
            end
            default: begin
                m_n++;
                if (m_n == DEAD) begin
                    m_owner = 0; m_n = 0;
                end
            end
        endcase
        m_ramp = ((m_owner == 1 && m_da < DA) || (m_owner == 2 && m_db < tgt)) ? 1 : 0;
    endtask

    task automatic compare_all();
        check("owner", owner, m_owner);
        check("duty_a", duty_a, m_da);
        check("duty_b", duty_b, m_db);
        check("ramping", ramping, m_ramp);
        check("exclusive", (duty_a != 0 && duty_b != 0), 0);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(pump_a_req, pump_b_mode);
        #1;
        compare_all();
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    // Pulse reset between edges; outputs must clear before any clock edge.
    task automatic async_reset();
        #2 reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        #2 reset = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        pump_a_req  = 1'b0;
        pump_b_mode = 2'b00;
        model_reset();
        @(posedge clk);
        #1;
        compare_all();
        reset = 1'b0;

        pump_a_req = 1'b1;
        step();
        check("a_owner_1cyc", owner, 1);
        steps(4);
        check("a_first_step", duty_a, 16);
        steps(60);
        check("a_saturated", duty_a, 255);
        check("a_ramp_done", ramping, 0);

        pump_a_req  = 1'b0;
        pump_b_mode = 2'b01;
        step();
        check("a_to_dead", owner, 3);
        check("a_dead_duty", duty_a, 0);
        steps(9);
        check("dead_hold", owner, 3);
        step();
        check("dead_done", owner, 0);
        step();
        check("b_owner", owner, 2);
        steps(30);
        check("b_min_hold", duty_b, 96);

        pump_b_mode = 2'b10;
        steps(45);
        check("b_max", duty_b, 255);
        pump_b_mode = 2'b01;
        step();
        check("b_drop", duty_b, 96);
        pump_b_mode = 2'b11;
        steps(8);
        check("b_rsvd_hold", duty_b, 96);
        check("b_rsvd_owner", owner, 2);

        pump_b_mode = 2'b00;
        steps(11);
        check("b_off_none", owner, 0);
        pump_a_req  = 1'b1;
        pump_b_mode = 2'b10;
        step();
        check("b_priority", owner, 2);
        check("b_priority_a0", duty_a, 0);
        steps(12);
        check("b_mid_ramp", duty_b, 48);
        async_reset();
        check("reset_duty_b", duty_b, 0);
        pump_a_req  = 1'b0;
        pump_b_mode = 2'b00;

        for (int i = 0; i < 3000; i++) begin
            step();
            if ($urandom_range(0, 599) == 0) async_reset();
            if ($urandom_range(0, 15) == 0) pump_a_req = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) pump_b_mode = 2'($urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
